mult_seq_nxn: RTL and testbench

//   Parametrised sequential shift-and-add multiplier, N x N -> 2N bits.

---
 rtl/mult_seq_pkg.sv | 20 ++
 rtl/mult_seq_ctrl.sv | 74 +++++++
 rtl/mult_seq_nxn.sv | 104 ++++++++++
 tb/tb_mult_seq_nxn.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential multiplier family: state encoding and
// the step-counter width helper (also used by the radix-4 variant).
package mult_seq_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } state_t;

    // The counter must be able to hold the value n, reached after the final step.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Control for the shift-and-add multiplier: IDLE/RUN/DONE FSM plus step counter.
// Emits load/step/fin strobes for the datapath and the busy/done handshake.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = cnt_w(N)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_load,
    output logic o_step,
    output logic o_fin,
    output logic o_busy,
    output logic o_done
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (o_load) begin
            r_cnt <= '0;
        end else if (o_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_load      = 1'b0;
        o_step      = 1'b0;
        o_fin       = 1'b0;
        o_busy      = (r_state != ST_IDLE);
        o_done      = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    o_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                o_step = 1'b1;
                if (w_last) begin
                    o_fin       = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mult_seq_nxn.sv
// Radix-2 sequential N x N -> 2N multiplier, one partial product per clock.
// Define MULT_SEQ_SIGNED_EN to add the sgn port and two's-complement operation.
module mult_seq_nxn
    import mult_seq_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = cnt_w(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   mplier,
    input  logic [N-1:0]   mcand,
`ifdef MULT_SEQ_SIGNED_EN
    input  logic           sgn,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    logic           w_load;
    logic           w_step;
    logic           w_fin;
    logic [2*N:0]   r_acc;
    logic [N-1:0]   r_mc;
    logic [2*N-1:0] r_product;
    logic [N-1:0]   w_mplier_eff;
    logic [N-1:0]   w_mcand_eff;
    logic [N:0]     w_hi;
    logic [2*N:0]   w_acc_nxt;
    logic [2*N-1:0] w_prod_fix;

    mult_seq_ctrl #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start),
        .o_load  (w_load),
        .o_step  (w_step),
        .o_fin   (w_fin),
        .o_busy  (busy),
        .o_done  (done)
    );

`ifdef MULT_SEQ_SIGNED_EN
    logic r_neg;
    logic w_neg_in;

    // Magnitude as N-bit unsigned; the most negative value maps to 2^(N-1), which fits.
    function automatic logic [N-1:0] abs_n(input logic [N-1:0] v);
        return v[N-1] ? (~v + 1'b1) : v;
    endfunction

    assign w_mplier_eff = sgn ? abs_n(mplier) : mplier;
    assign w_mcand_eff  = sgn ? abs_n(mcand)  : mcand;
    assign w_neg_in     = sgn & (mplier[N-1] ^ mcand[N-1]);
    assign w_prod_fix   = r_neg ? (~w_acc_nxt[2*N-1:0] + 1'b1) : w_acc_nxt[2*N-1:0];

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_neg <= w_neg_in;
        end
    end
`else
    assign w_mplier_eff = mplier;
    assign w_mcand_eff  = mcand;
    assign w_prod_fix   = w_acc_nxt[2*N-1:0];
`endif

    // Add and shift in one step; the adder carry lands in the top bit and is shifted down.
    assign w_hi      = r_acc[2*N:N] + (r_acc[0] ? {1'b0, r_mc} : '0);
    assign w_acc_nxt = {1'b0, w_hi, r_acc[N-1:1]};

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_mc <= w_mcand_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_load) begin
            r_acc <= {{(N+1){1'b0}}, w_mplier_eff};
        end else if (w_step) begin
            r_acc <= w_acc_nxt;
        end
    end

    // Result is only updated on the final step so it stays stable between done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
        end else if (w_fin) begin
            r_product <= w_prod_fix;
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Bench for mult_seq_nxn (N=16): vector table, hand-written corner sequences,
// random operands, and a queue scoreboard that checks every done pulse.
module tb_mult_seq_nxn;

    localparam int N  = 16;
    localparam int PW = 2 * N;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic [N-1:0]  mplier = '0;
    logic [N-1:0]  mcand  = '0;
    logic          sgn    = 1'b0;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_done = -1;
    logic [PW-1:0] sb_q[$];

    typedef struct {
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic          s;
        logic [PW-1:0] e;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    mult_seq_nxn #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mplier  (mplier),
        .mcand   (mcand),
`ifdef MULT_SEQ_SIGNED_EN
        .sgn     (sgn),
`endif
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic s);
        longint x, y;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({1'b0, a});
            y = longint'({1'b0, b});
        end
        return PW'(x * y);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every done pops one expected product; also checks op spacing.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_done = -1;
        end else if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                chk("product", {32'd0, product}, {32'd0, sb_q.pop_front()});
            end
            if (last_done >= 0) begin
                chk("done_spacing", 64'(cyc - last_done >= N + 2), 64'd1);
            end
            last_done = cyc;
        end
    end

    // One operation: start for one cycle, optional ignored start at RUN cycle 'poke',
    // optional hold check of the previous product at RUN cycle 3.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          input logic [PW-1:0] e, input bit use_model, input int poke,
                          input bit chk_hold, input logic [PW-1:0] prev,
                          output int lat, output int bcnt);
        bit got;
        @(posedge clk);
        #1;
        mplier = a;
        mcand  = b;
        sgn    = s;
        start  = 1'b1;
        sb_q.push_back(use_model ? model(mplier, mcand, sgn) : e);
        @(posedge clk);
        #1;
        start  = 1'b0;
        mplier = N'($urandom);
        mcand  = N'($urandom);
        lat  = 0;
        bcnt = 0;
        got  = 0;
        for (int i = 1; i <= N + 4 && !got; i++) begin
            @(negedge clk);
            if (poke > 0 && i == poke) begin
                start  = 1'b1;
                mplier = N'($urandom);
                mcand  = N'($urandom);
            end else begin
                start = 1'b0;
            end
            if (chk_hold && i == 3) chk("hold_during_run", {32'd0, product}, {32'd0, prev});
            if (busy) bcnt++;
            if (done) begin
                got = 1;
                lat = i;
            end
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt;
        logic rs;
        logic [N-1:0] ra, rb;

        tv.push_back('{16'h0003, 16'h0005, 1'b0, 32'h0000000F});
        tv.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
        tv.push_back('{16'h0000, 16'h1234, 1'b0, 32'h00000000});
        tv.push_back('{16'h1234, 16'h0000, 1'b0, 32'h00000000});
        tv.push_back('{16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE});
        tv.push_back('{16'h8000, 16'h8000, 1'b0, 32'h40000000});
        tv.push_back('{16'h0001, 16'hFFFF, 1'b0, 32'h0000FFFF});
        tv.push_back('{16'h00FF, 16'h0100, 1'b0, 32'h0000FF00});
        tv.push_back('{16'h8001, 16'h0003, 1'b0, 32'h00018003});
        tv.push_back('{16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF0001});
`ifdef MULT_SEQ_SIGNED_EN
        tv.push_back('{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1});
        tv.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000});
        tv.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001});
        tv.push_back('{16'h0005, 16'hFFFD, 1'b1, 32'hFFFFFFF1});
        tv.push_back('{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000});
        tv.push_back('{16'h0000, 16'hFFFF, 1'b1, 32'h00000000});
`endif

        repeat (2) @(negedge clk);
        chk("reset_busy",    {63'd0, busy}, 64'd0);
        chk("reset_done",    {63'd0, done}, 64'd0);
        chk("reset_product", {32'd0, product}, 64'd0);
        rst_n = 1'b1;

        // Latency, busy length and single-cycle done for 3*5.
        run_op(16'd3, 16'd5, 1'b0, 32'h0000000F, 0, 0, 0, '0, lat, bcnt);
        chk("latency_3x5", 64'(lat), 64'd17);
        chk("busy_cycles_3x5", 64'(bcnt), 64'd17);
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("busy_back_idle", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("product_hold_idle", {32'd0, product}, 64'h0000000F);

        // Start pulsed mid-run is ignored; previous product holds until the new done.
        run_op(16'h1234, 16'h00AB, 1'b0, 32'h000C28BC, 0, 5, 1, 32'h0000000F, lat, bcnt);
        chk("latency_ignored_start", 64'(lat), 64'd17);
        repeat (N + 6) @(negedge clk);
        chk("no_queued_op", {63'd0, busy}, 64'd0);

        // Table vectors, issued back-to-back.
        foreach (tv[k]) begin
            run_op(tv[k].a, tv[k].b, tv[k].s, tv[k].e, 0, 0, 0, '0, lat, bcnt);
        end
        run_op(16'h0002, 16'h0009, 1'b0, 32'h00000012, 0, 0, 0, '0, lat, bcnt);
        chk("latency_back_to_back", 64'(lat), 64'd17);

        // Reset in the 8th RUN cycle aborts at once and produces no done.
        @(posedge clk);
        #1;
        mplier = 16'h1234;
        mcand  = 16'h5678;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",    {63'd0, busy}, 64'd0);
        chk("abort_done",    {63'd0, done}, 64'd0);
        chk("abort_product", {32'd0, product}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        chk("abort_product_after", {32'd0, product}, 64'd0);
        run_op(16'd7, 16'd6, 1'b0, 32'd42, 0, 0, 0, '0, lat, bcnt);
        chk("latency_after_abort", 64'(lat), 64'd17);

        // Random operands against the behavioural model.
        for (int r = 0; r < 200; r++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (r % 17 == 0) ra = '0;
            if (r % 23 == 0) rb = '1;
`ifdef MULT_SEQ_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rs, '0, 1, 0, 0, '0, lat, bcnt);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
